ppl_hazard_ctrl: RTL and testbench
==================================

// Module: ppl_hazard_ctrl
// PURPOSE
// Pipeline sequencer for the 5-stage core. Sits beside the ID stage; watches ID, EX and MEM
// register-write info and drives PC/IF-ID write enables, the ID/EX bubble, IF-ID flush and
// operand-forward selects. Also owns the busy counter for the multi-cycle mul/div unit.
// PARAMETERS
// MD_LAT   32  cycles the mul/div unit needs from start to result (>=2)
// CNT_W    32  width of the saturating stall-cycle performance counter
// PORTS
// clk           in   1      rising-edge clock
// reset         in   1      synchronous, active-low reset
// dRs, dRt      in   5      ID source register numbers
// dUseRs,dUseRt in   1      ID instruction actually reads rs / rt
// dMulDiv       in   1      ID instruction starts mul/div
// dMdRead       in   1      ID instruction reads HI/LO (mfhi/mflo)
// dBranchTaken  in   1      branch/jump resolved taken in ID
// exWriteReg    in   1      EX instr writes regfile
// exMem2Reg     in   1      EX instr is a load
// exReg0        in   5      EX destination register
// mWriteReg     in   1      MEM instr writes regfile
// mMem2Reg      in   1      MEM instr is a load
// mReg          in   5      MEM destination register
// pcWrite       out  1      PC update enable
// ifidWrite     out  1      IF/ID register enable
// ifidFlush     out  1      IF/ID load NOP
// idexBubble    out  1      force ID/EX control bits (WriteReg/Mem2Reg/WriteMem/Jal) to 0
// fwdA, fwdB    out  2      0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data
// mdStart       out  1      one-cycle start pulse to mul/div unit
// mdBusy        out  1      mul/div in progress
// stallCount    out  CNT_W  stall cycles since reset, saturates at all-ones
// BEHAVIOUR
// - Reset: while reset==0 at posedge, state->IDLE, counter->0, stallCount->0. Combinational
//   outputs while reset==0: pcWrite=0 ifidWrite=0 ifidFlush=1 idexBubble=1 fwdA=fwdB=0 mdStart=0.
// - Register 0 never matches any hazard or forward compare.
// - Forward (per operand, EX priority): EX match & exWriteReg & !exMem2Reg ->1;
//   else MEM match & mWriteReg -> (mMem2Reg ? 3 : 2); else 0. Gated by dUseRs/dUseRt.
// - Load-use stall: exWriteReg & exMem2Reg & exReg0!=0 & matches used rs/rt -> 1-cycle stall.
// - MD stall: mdBusy & (dMulDiv | dMdRead).
// - stall = load-use | MD stall. When stall: pcWrite=0 ifidWrite=0 idexBubble=1, ifidFlush=0,
//   mdStart=0. Stall overrides dBranchTaken (branch is re-evaluated next cycle).
// - No stall: pcWrite=ifidWrite=1, idexBubble=0, ifidFlush=dBranchTaken (no delay slot).
// - FSM IDLE/BUSY, counter width $clog2(MD_LAT+1):
//   IDLE: dMulDiv & !stall -> mdStart=1, cnt<=MD_LAT-1, ->BUSY.
//   BUSY: cnt!=0 -> cnt<=cnt-1; cnt==0 -> IDLE (mdBusy low next cycle, result readable).
//   mdBusy=(state==BUSY). mdStart never asserts in BUSY.
// - Latency: all control outputs combinational from inputs+state; state updates at posedge.
// - stallCount increments every non-reset cycle with stall=1; holds at 2^CNT_W-1.
// - Reset mid-BUSY: aborts sequence, IDLE next cycle, no mdStart until reset released.
// STRUCTURE
// - Shared package/header ppl_defs: FWD_RF=2'd0 FWD_EXALU=2'd1 FWD_MEMALU=2'd2 FWD_MEMLD=2'd3,
//   state encodings MD_IDLE/MD_BUSY.
// - One sub-module: ppl_fwd_sel (pure compare/priority logic), instantiated twice for A and B.
// - FSM, counters and stall/flush glue live in this module.
// TESTING
// - exWriteReg=1 exMem2Reg=1 exReg0=5, dRs=5 dUseRs=1 -> 1 cycle pcWrite=0 idexBubble=1, then fwdA=3.
// - exReg0=7 ALU op, mReg=7 load, dRt=7 dUseRt=1 -> fwdB=1 (EX wins); exReg0=0 -> fwdB=3.
// - dMulDiv=1 MD_LAT=4 -> mdStart 1 cycle, mdBusy 4 cycles; dMdRead during busy stalls 4, releases.
// - Load-use stall coincident with dBranchTaken=1 -> ifidFlush=0 that cycle; next cycle flush=1.
// - reset=0 during BUSY -> mdBusy=0 next cycle, stallCount=0; dRs=0 with exReg0=0 -> no stall, fwdA=0.
// - Force 2^CNT_W stall cycles (CNT_W=4 build) -> stallCount sticks at 15.

Source files
------------

// File: rtl/ppl_defs.sv
// Shared encodings for the pipeline sequencer: forward-select codes and mul/div FSM states.
package ppl_defs;

    localparam logic [1:0] FWD_RF     = 2'd0;
    localparam logic [1:0] FWD_EXALU  = 2'd1;
    localparam logic [1:0] FWD_MEMALU = 2'd2;
    localparam logic [1:0] FWD_MEMLD  = 2'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    // $zero is hardwired, so it can never carry a real dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/ppl_fwd_sel.sv
// Operand forward-select for one ID source register; EX stage has priority over MEM.
module ppl_fwd_sel
    import ppl_defs::*;
(
    input  logic [4:0] srcReg,
    input  logic       useSrc,
    input  logic       exWriteReg,
    input  logic       exMem2Reg,
    input  logic [4:0] exReg0,
    input  logic       mWriteReg,
    input  logic       mMem2Reg,
    input  logic [4:0] mReg,
    output logic [1:0] fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (useSrc) begin
            // An EX-stage load has no data yet; the load-use stall covers it instead.
            if (exWriteReg && !exMem2Reg && regMatch(srcReg, exReg0))
                fwdSel = FWD_EXALU;
            else if (mWriteReg && regMatch(srcReg, mReg))
                fwdSel = mMem2Reg ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/ppl_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/forward control for the 5-stage core plus mul/div busy tracking.
module ppl_hazard_ctrl
    import ppl_defs::*;
#(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       dRs,
    input  logic [4:0]       dRt,
    input  logic             dUseRs,
    input  logic             dUseRt,
    input  logic             dMulDiv,
    input  logic             dMdRead,
    input  logic             dBranchTaken,
    input  logic             exWriteReg,
    input  logic             exMem2Reg,
    input  logic [4:0]       exReg0,
    input  logic             mWriteReg,
    input  logic             mMem2Reg,
    input  logic [4:0]       mReg,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             mdStart,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    localparam int unsigned CW = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

    mdState_t   state;
    logic [CW-1:0] cnt;
    logic [1:0] selA;
    logic [1:0] selB;
    logic       loadUse;
    logic       mdStall;
    logic       stall;
    logic       startReq;

    ppl_fwd_sel uFwdA (
        .srcReg     (dRs),
        .useSrc     (dUseRs),
        .exWriteReg (exWriteReg),
        .exMem2Reg  (exMem2Reg),
        .exReg0     (exReg0),
        .mWriteReg  (mWriteReg),
        .mMem2Reg   (mMem2Reg),
        .mReg       (mReg),
        .fwdSel     (selA)
    );

    ppl_fwd_sel uFwdB (
        .srcReg     (dRt),
        .useSrc     (dUseRt),
        .exWriteReg (exWriteReg),
        .exMem2Reg  (exMem2Reg),
        .exReg0     (exReg0),
        .mWriteReg  (mWriteReg),
        .mMem2Reg   (mMem2Reg),
        .mReg       (mReg),
        .fwdSel     (selB)
    );

    assign loadUse  = exWriteReg && exMem2Reg &&
                      ((dUseRs && regMatch(dRs, exReg0)) || (dUseRt && regMatch(dRt, exReg0)));
    assign mdBusy   = (state == MD_BUSY);
    assign mdStall  = mdBusy && (dMulDiv || dMdRead);
    assign stall    = loadUse || mdStall;
    assign startReq = (state == MD_IDLE) && dMulDiv && !stall;

    always_comb begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
        fwdA       = FWD_RF;
        fwdB       = FWD_RF;
        mdStart    = 1'b0;
        if (reset) begin
            fwdA    = selA;
            fwdB    = selB;
            mdStart = startReq;
            // A stalled branch is simply re-evaluated next cycle, so no flush now.
            if (stall) begin
                ifidFlush = 1'b0;
            end else begin
                pcWrite    = 1'b1;
                ifidWrite  = 1'b1;
                idexBubble = 1'b0;
                ifidFlush  = dBranchTaken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= MD_IDLE;
            cnt        <= '0;
            stallCount <= '0;
        end else begin
            if (stall && (stallCount != '1))
                stallCount <= stallCount + 1'b1;
            case (state)
                MD_IDLE: begin
                    if (startReq) begin
                        cnt   <= CNT_INIT;
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else
                        state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppl_hazard_ctrl.sv
// Directed self-checking bench for ppl_hazard_ctrl (MD_LAT=4, CNT_W=4 build).
module tb_ppl_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] dRs, dRt, exReg0, mReg;
    logic       dUseRs, dUseRt, dMulDiv, dMdRead, dBranchTaken;
    logic       exWriteReg, exMem2Reg, mWriteReg, mMem2Reg;
    logic       pcWrite, ifidWrite, ifidFlush, idexBubble, mdStart, mdBusy;
    logic [1:0] fwdA, fwdB;
    logic [3:0] stallCount;

    int errCnt = 0;
    int chkCnt = 0;

    always #5 clk = ~clk;

    ppl_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .dRs          (dRs),
        .dRt          (dRt),
        .dUseRs       (dUseRs),
        .dUseRt       (dUseRt),
        .dMulDiv      (dMulDiv),
        .dMdRead      (dMdRead),
        .dBranchTaken (dBranchTaken),
        .exWriteReg   (exWriteReg),
        .exMem2Reg    (exMem2Reg),
        .exReg0       (exReg0),
        .mWriteReg    (mWriteReg),
        .mMem2Reg     (mMem2Reg),
        .mReg         (mReg),
        .pcWrite      (pcWrite),
        .ifidWrite    (ifidWrite),
        .ifidFlush    (ifidFlush),
        .idexBubble   (idexBubble),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .mdStart      (mdStart),
        .mdBusy       (mdBusy),
        .stallCount   (stallCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        dRs = '0; dRt = '0; exReg0 = '0; mReg = '0;
        dUseRs = 0; dUseRt = 0; dMulDiv = 0; dMdRead = 0; dBranchTaken = 0;
        exWriteReg = 0; exMem2Reg = 0; mWriteReg = 0; mMem2Reg = 0;
    endtask

    initial begin
        reset = 1'b0;
        clearIn();
        dMulDiv = 1;
        tick();
        tick();
        #1;
        checkVal("rst_pcWrite", pcWrite, 0);
        checkVal("rst_ifidWrite", ifidWrite, 0);
        checkVal("rst_ifidFlush", ifidFlush, 1);
        checkVal("rst_idexBubble", idexBubble, 1);
        checkVal("rst_fwdA", fwdA, 0);
        checkVal("rst_mdStart", mdStart, 0);
        checkVal("rst_mdBusy", mdBusy, 0);
        checkVal("rst_stallCount", stallCount, 0);

        // Normal flow after reset release
        reset = 1'b1;
        clearIn();
        tick();
        #1;
        checkVal("run_pcWrite", pcWrite, 1);
        checkVal("run_idexBubble", idexBubble, 0);
        checkVal("run_ifidFlush", ifidFlush, 0);

        // Load-use on rs coincident with a taken branch
        exWriteReg = 1; exMem2Reg = 1; exReg0 = 5; dRs = 5; dUseRs = 1; dBranchTaken = 1;
        #1;
        checkVal("lu_pcWrite", pcWrite, 0);
        checkVal("lu_ifidWrite", ifidWrite, 0);
        checkVal("lu_idexBubble", idexBubble, 1);
        checkVal("lu_ifidFlush", ifidFlush, 0);
        checkVal("lu_fwdA", fwdA, 0);
        tick();
        exWriteReg = 0; exMem2Reg = 0; exReg0 = 0;
        mWriteReg = 1; mMem2Reg = 1; mReg = 5;
        #1;
        checkVal("lu2_fwdA", fwdA, 3);
        checkVal("lu2_pcWrite", pcWrite, 1);
        checkVal("lu2_ifidFlush", ifidFlush, 1);
        checkVal("lu2_stallCount", stallCount, 1);

        // Forwarding priority on rt
        clearIn();
        exWriteReg = 1; exReg0 = 7; mWriteReg = 1; mMem2Reg = 1; mReg = 7; dRt = 7; dUseRt = 1;
        #1;
        checkVal("fwdB_ex", fwdB, 1);
        checkVal("fwdB_exA", fwdA, 0);
        exReg0 = 0;
        #1;
        checkVal("fwdB_memld", fwdB, 3);
        mMem2Reg = 0;
        #1;
        checkVal("fwdB_memalu", fwdB, 2);
        dUseRt = 0;
        #1;
        checkVal("fwdB_unused", fwdB, 0);
        clearIn();
        exWriteReg = 1; exMem2Reg = 1; exReg0 = 0; dRs = 0; dUseRs = 1;
        #1;
        checkVal("r0_pcWrite", pcWrite, 1);
        checkVal("r0_fwdA", fwdA, 0);

        // Mul/div start, then mfhi-style reads stall for the whole busy window
        clearIn();
        dMulDiv = 1;
        #1;
        checkVal("md_start", mdStart, 1);
        checkVal("md_startPc", pcWrite, 1);
        checkVal("md_busyPre", mdBusy, 0);
        tick();
        dMulDiv = 0; dMdRead = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkVal($sformatf("md_busy%0d", i), mdBusy, 1);
            checkVal($sformatf("md_stall%0d", i), pcWrite, 0);
            checkVal($sformatf("md_noStart%0d", i), mdStart, 0);
            tick();
        end
        #1;
        checkVal("md_done", mdBusy, 0);
        checkVal("md_release", pcWrite, 1);
        checkVal("md_stallCount", stallCount, 5);

        // Reset in the middle of a busy sequence
        dMdRead = 0; dMulDiv = 1;
        tick();
        dMulDiv = 0;
        tick();
        #1;
        checkVal("mr_busy", mdBusy, 1);
        reset = 1'b0; dMulDiv = 1;
        #1;
        checkVal("mr_noStart", mdStart, 0);
        tick();
        #1;
        checkVal("mr_busyCleared", mdBusy, 0);
        checkVal("mr_stallCount", stallCount, 0);
        tick();
        #1;
        checkVal("mr_holdIdle", mdBusy, 0);
        reset = 1'b1; clearIn();

        // Saturation of the stall counter
        exWriteReg = 1; exMem2Reg = 1; exReg0 = 3; dRs = 3; dUseRs = 1;
        for (int i = 0; i < 15; i++) tick();
        #1;
        checkVal("sat_reach", stallCount, 15);
        for (int i = 0; i < 5; i++) tick();
        #1;
        checkVal("sat_hold", stallCount, 15);
        checkVal("sat_stall", pcWrite, 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
